sample_player: RTL and testbench
================================

Name: sample_player

Overview:
- Synthesizable, parametrised baseband sample source for the dot11 receiver chain.
- Replaces the fixed "one sample every 5 clocks" stimulus generator used in simulation.
- Holds a preloaded sample buffer of NUM_CHAN channels. Streams it to sample_in/sample_in_strobe of dot11 at a programmable strobe interval, in one-shot or loop mode, with an optional idle gap between loops.
- Configured over the existing set_stb/set_addr/set_data settings bus. Used both on FPGA (over-the-air replay) and in benches.

Parameters:
- DATA_WIDTH, 32: bits per channel sample; I in [31:16], Q in [15:0].
- NUM_CHAN, 1: number of parallel channels (antennas), packed channel 0 in the LSBs.
- ADDR_WIDTH, 10: buffer depth is 2**ADDR_WIDTH samples.
- SR_BASE, 8'd20: settings base address. Registers:
  - SR_BASE+0 = INTERVAL
  - SR_BASE+1 = LEN
  - SR_BASE+2 = GAP
  - SR_BASE+3 = CTRL

Ports:
- clock, input, 1: single clock.
- reset, input, 1: asynchronous, active-low reset.
- set_stb, input, 1: settings write strobe.
- set_addr, input, 8: settings address.
- set_data, input, 32: settings data.
- wr_en, input, 1: buffer load enable.
- wr_addr, input, ADDR_WIDTH: buffer load address.
- wr_data, input, NUM_CHAN*DATA_WIDTH: buffer load data.
- sample_out, output, NUM_CHAN*DATA_WIDTH: played sample, held between strobes.
- sample_out_strobe, output, 1: one-cycle valid pulse.
- busy, output, 1: high in PLAY or GAP.
- done, output, 1: one-cycle pulse at one-shot completion.
- play_addr, output, ADDR_WIDTH: address of the next sample to play.
- loop_count, output, 16: completed loop passes, saturating.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, state IDLE, all settings registers 0. The buffer contents are not reset.
- Settings registers:
  - INTERVAL[15:0] = I. The strobe period is I+1 cycles; I=0 gives a strobe every cycle.
  - LEN[ADDR_WIDTH:0] = N samples per pass. Values above 2**ADDR_WIDTH clamp to 2**ADDR_WIDTH.
  - GAP[15:0] = G idle cycles between loop passes.
  - CTRL: bit0 start, bit1 loop, bit2 stop. Start and stop are self-clearing actions; the loop bit is stored.
- Shadowing: I, N, G and the loop bit are latched into shadow registers on start. Writes during play affect only the next start.
- Buffer load port:
  - Written on any cycle, including during play.
  - A written value is readable by the player from the next cycle onward.
- States: IDLE, PLAY, GAP.
- IDLE:
  - On start with N>0: go to PLAY, play_addr=0, cycle counter=0, loop_count=0.
  - On start with N=0: ignored.
- PLAY:
  - The counter increments every cycle.
  - When counter==I: counter<=0, sample_out<=buf[play_addr], sample_out_strobe<=1, play_addr++.
  - The first strobe is high during cycle I+1 after the start edge (start edge = cycle 0). Subsequent strobes follow every I+1 cycles.
- End of pass (the edge issuing the Nth strobe):
  - One-shot: go to IDLE. done is high in the cycle after the last strobe. play_addr returns to 0.
  - Loop with G>0: go to GAP. loop_count++ (saturates at 16'hFFFF).
  - Loop with G=0: restart PLAY at address 0 with no extra cycles. The strobe spacing stays exactly I+1 across the wrap. loop_count++.
- GAP:
  - Counts G cycles with no strobes, then enters PLAY with play_addr=0 and counter=0.
  - The next strobe comes I+1 cycles after GAP exits.
- Address wrap: play_addr wraps to 0 when N = 2**ADDR_WIDTH.
- stop (any state): next edge goes to IDLE, sample_out_strobe=0, play_addr=0, no done pulse. sample_out and loop_count hold their values.
- Start and stop set in the same CTRL write: stop wins.
- Start while busy: restart from address 0 with new shadows and loop_count=0. Any pending strobe is not issued.
- Reset asserted mid-play: outputs go to 0 immediately. After release the block is IDLE.
- busy equals the state not being IDLE, registered.

Test Plan:
- Load buf[0..3]=0x00010002,0x00030004,0x00050006,0x00070008; I=4, N=4, one-shot, start → 4 strobes at cycles 5,10,15,20 carrying those words in order; done pulses at cycle 21; busy falls at 21.
- Same buffer; I=0, N=4, loop, G=0 → continuous strobes every cycle with words 0,1,2,3,0,1,...; loop_count reads 1 after the 4th strobe and 2 after the 8th.
- I=1, N=2, loop, G=3 → strobes at cycles 2 and 4; no strobe during cycles 5..7; next strobe at cycle 9 carrying buf[0].
- Start, then stop after the 2nd strobe; also a single CTRL write with start+stop → no further strobes, no done, busy=0, play_addr=0; the combined write never starts play.
- Start with N=0 → nothing happens. N=2**ADDR_WIDTH, I=0 → play_addr wraps and done fires after exactly 1024 strobes.
- Assert reset during PLAY → sample_out, strobe, busy and loop_count all 0 asynchronously. A fresh start after release plays from address 0.

Source files
------------

// File: rtl/sample_player.sv
// Baseband sample source: streams a preloaded multi-channel buffer at a
// programmable strobe interval, one-shot or looped with an optional idle gap.
module sample_player #(
  parameter int         DATA_WIDTH = 32,
  parameter int         NUM_CHAN   = 1,
  parameter int         ADDR_WIDTH = 10,
  parameter logic [7:0] SR_BASE    = 8'd20
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [NUM_CHAN*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_CHAN*DATA_WIDTH-1:0] sample_out,
  output logic                           sample_out_strobe,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          play_addr,
  output logic [15:0]                    loop_count
);
  localparam int SW    = NUM_CHAN * DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LEN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} state_t;
  state_t state_r, state_nxt;

  logic [SW-1:0]       mem [DEPTH];
  logic [15:0]         interval_r, gap_r, ish_r, gsh_r, cnt_r, gap_cnt_r;
  logic [ADDR_WIDTH:0] len_r, nsh_r, len_clamp_s;
  logic                loop_r, loop_sh_r, done_pend_r;
  logic                ctrl_wr_s, start_s, stop_s, loop_now_s, last_s;
  logic                fire_s, restart_s, pass_end_s, gap_exit_s;
  logic                unused_bits;

  assign ctrl_wr_s   = set_stb && (set_addr == SR_BASE + 8'd3);
  assign stop_s      = ctrl_wr_s && set_data[2];
  assign start_s     = ctrl_wr_s && set_data[0] && !set_data[2] && (len_r != LEN_ZERO);
  assign loop_now_s  = ctrl_wr_s ? set_data[1] : loop_r;
  assign last_s      = ({1'b0, play_addr} == (nsh_r - LEN_ONE));
  assign len_clamp_s = (set_data[ADDR_WIDTH:0] > LEN_MAX) ? LEN_MAX : set_data[ADDR_WIDTH:0];
  assign unused_bits = ^set_data[31:16];

  // Settings registers written over the settings bus
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interval_r <= 16'd0;
      len_r      <= LEN_ZERO;
      gap_r      <= 16'd0;
      loop_r     <= 1'b0;
    end else if (set_stb) begin
      case (set_addr)
        SR_BASE:         interval_r <= set_data[15:0];
        SR_BASE + 8'd1:  len_r      <= len_clamp_s;
        SR_BASE + 8'd2:  gap_r      <= set_data[15:0];
        SR_BASE + 8'd3:  loop_r     <= set_data[1];
        default:         loop_r     <= loop_r;
      endcase
    end
  end

  // Sample buffer load port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and event decode; stop beats start, start beats playback
  always_comb begin
    state_nxt  = state_r;
    fire_s     = 1'b0;
    restart_s  = 1'b0;
    pass_end_s = 1'b0;
    gap_exit_s = 1'b0;
    if (stop_s) begin
      state_nxt = ST_IDLE;
    end else if (start_s) begin
      state_nxt = ST_PLAY;
      restart_s = 1'b1;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (cnt_r == ish_r) begin
            fire_s = 1'b1;
            if (last_s) begin
              pass_end_s = 1'b1;
              if (!loop_sh_r) begin
                state_nxt = ST_IDLE;
              end else if (gsh_r != 16'd0) begin
                state_nxt = ST_GAP;
              end else begin
                state_nxt = ST_PLAY;
              end
            end else begin
              state_nxt = ST_PLAY;
            end
          end else begin
            state_nxt = ST_PLAY;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == gsh_r - 16'd1) begin
            gap_exit_s = 1'b1;
            state_nxt  = ST_PLAY;
          end else begin
            state_nxt = ST_GAP;
          end
        end
        ST_IDLE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Playback datapath: counters, shadows and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample_out        <= {SW{1'b0}};
      sample_out_strobe <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      done_pend_r       <= 1'b0;
      play_addr         <= ADDR_ZERO;
      loop_count        <= 16'd0;
      cnt_r             <= 16'd0;
      gap_cnt_r         <= 16'd0;
      ish_r             <= 16'd0;
      nsh_r             <= LEN_ZERO;
      gsh_r             <= 16'd0;
      loop_sh_r         <= 1'b0;
    end else begin
      busy              <= (state_r != ST_IDLE);
      done_pend_r       <= pass_end_s && !loop_sh_r;
      done              <= done_pend_r;
      sample_out_strobe <= fire_s;
      if (fire_s) begin
        sample_out <= mem[play_addr];
      end
      if (stop_s) begin
        play_addr <= ADDR_ZERO;
        cnt_r     <= 16'd0;
        gap_cnt_r <= 16'd0;
      end else if (restart_s) begin
        play_addr  <= ADDR_ZERO;
        cnt_r      <= 16'd0;
        gap_cnt_r  <= 16'd0;
        loop_count <= 16'd0;
        ish_r      <= interval_r;
        nsh_r      <= len_r;
        gsh_r      <= gap_r;
        loop_sh_r  <= loop_now_s;
      end else if (fire_s) begin
        cnt_r     <= 16'd0;
        gap_cnt_r <= 16'd0;
        play_addr <= pass_end_s ? ADDR_ZERO : play_addr + ADDR_ONE;
        if (pass_end_s && loop_sh_r && (loop_count != 16'hFFFF)) begin
          loop_count <= loop_count + 16'd1;
        end
      end else if (gap_exit_s) begin
        cnt_r     <= 16'd0;
        play_addr <= ADDR_ZERO;
      end else if (state_r == ST_PLAY) begin
        cnt_r <= cnt_r + 16'd1;
      end else if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_sample_player.sv
// Bench for sample_player: directed and random configurations compared every
// cycle against an arithmetic model of the strobe schedule.
module tb_sample_player;
  localparam int         AW      = 10;
  localparam int         DEPTH   = 1024;
  localparam logic [7:0] SR_BASE = 8'd20;

  logic          clock, reset, set_stb, wr_en;
  logic [7:0]    set_addr;
  logic [31:0]   set_data, wr_data, sample_out;
  logic [AW-1:0] wr_addr, play_addr;
  logic          sample_out_strobe, busy, done;
  logic [15:0]   loop_count;

  sample_player #(.DATA_WIDTH(32), .NUM_CHAN(1), .ADDR_WIDTH(AW), .SR_BASE(SR_BASE)) dut (
    .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sample_out(sample_out), .sample_out_strobe(sample_out_strobe), .busy(busy),
    .done(done), .play_addr(play_addr), .loop_count(loop_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [31:0] ref_mem [DEPTH];
  int          n_checks, n_fail;
  int          rI, rN, rG;
  bit          prev_active;
  logic [31:0] m_sample;
  int          m_loops;
  int          strobes_seen;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit e_stb, input bit e_busy,
                               input bit e_done, input int e_addr);
    check_val({tag, ".strobe"}, 64'(sample_out_strobe), 64'(e_stb));
    check_val({tag, ".busy"},   64'(busy),              64'(e_busy));
    check_val({tag, ".done"},   64'(done),              64'(e_done));
    check_val({tag, ".addr"},   64'(play_addr),         64'(e_addr));
    check_val({tag, ".loops"},  64'(loop_count),        64'(m_loops));
    check_val({tag, ".sample"}, 64'(sample_out),        64'(m_sample));
  endtask

  // All tasks below start and end on a falling clock edge.
  task automatic write_reg(input int off, input logic [31:0] val);
    set_stb  = 1'b1;
    set_addr = SR_BASE + 8'(off);
    set_data = val;
    @(negedge clock);
    set_stb = 1'b0;
    case (off)
      0:       rI = int'(val[15:0]);
      1:       rN = (val[10:0] > 11'd1024) ? 1024 : int'(val[10:0]);
      2:       rG = int'(val[15:0]);
      default: rI = rI;
    endcase
  endtask

  task automatic load_word(input int addr, input logic [31:0] val);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = val;
    @(negedge clock);
    wr_en = 1'b0;
    ref_mem[addr] = val;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      set_stb = 1'b0;
      check_outputs(tag, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  // Start a pass with the current register model; cycle 0 is the start edge.
  // Strobe k of pass p lands at p*(N*(I+1)+G) + k*(I+1).
  task automatic run(input string tag, input bit loop, input int ncyc,
                     input int stop_at, input int new_i);
    int per, P, p, u, k, e_addr, cN;
    bit e_stb, e_done, act, stopped;
    cN  = rN;
    per = rI + 1;
    P   = cN * per + (loop ? rG : 0);
    set_stb  = 1'b1;
    set_addr = SR_BASE + 8'd3;
    set_data = {29'd0, 1'b0, loop, 1'b1};
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clock);
      set_stb = 1'b0;
      stopped = (stop_at >= 0) && (t >= stop_at);
      e_stb = 1'b0; e_done = 1'b0; e_addr = 0; act = 1'b0;
      if (stopped) begin
        act = 1'b0;
      end else if (!loop && t > cN * per) begin
        e_done = (t == cN * per + 1);
      end else begin
        if (t == 0) begin
          p = 0; u = 0;
        end else begin
          p = (t - 1) / P; u = t - p * P;
        end
        k      = u / per;
        e_stb  = (u > 0) && (u % per == 0) && (k <= cN);
        e_addr = (k >= cN) ? 0 : k;
        act    = loop || (t < cN * per);
        if (loop && t >= cN * per)
          m_loops = ((t - cN * per) / P + 1 > 65535) ? 65535 : (t - cN * per) / P + 1;
        else
          m_loops = 0;
        if (e_stb) m_sample = ref_mem[k-1];
      end
      check_outputs(tag, e_stb, prev_active, e_done, e_addr);
      prev_active = act;
      if (sample_out_strobe) strobes_seen++;
      if (t + 1 == stop_at) begin
        set_stb = 1'b1; set_addr = SR_BASE + 8'd3; set_data = 32'd4;
      end else if (t == 1 && new_i >= 0) begin
        set_stb = 1'b1; set_addr = SR_BASE; set_data = 32'(new_i); rI = new_i;
      end
    end
  endtask

  bit lp;
  int nc, sa, ni;

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    wr_en = 1'b0; wr_addr = '0; wr_data = 32'd0;
    rI = 0; rN = 0; rG = 0;
    prev_active = 1'b0; m_sample = 32'd0; m_loops = 0; strobes_seen = 0;
    repeat (3) @(negedge clock);
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
    load_word(0, 32'h00010002);
    load_word(1, 32'h00030004);
    load_word(2, 32'h00050006);
    load_word(3, 32'h00070008);

    // LEN is still zero: start must be ignored
    set_stb = 1'b1; set_addr = SR_BASE + 8'd3; set_data = 32'd1;
    idle_check("len0", 6);

    write_reg(0, 32'd4); write_reg(1, 32'd4); write_reg(2, 32'd0);
    run("oneshot", 1'b0, 24, -1, -1);
    write_reg(0, 32'd0);
    run("loop_g0", 1'b1, 13, 10, -1);
    write_reg(0, 32'd1); write_reg(1, 32'd2); write_reg(2, 32'd3);
    run("loop_gap", 1'b1, 20, 18, -1);
    write_reg(0, 32'd4); write_reg(1, 32'd4); write_reg(2, 32'd0);
    run("stop", 1'b0, 26, 12, -1);

    set_stb = 1'b1; set_addr = SR_BASE + 8'd3; set_data = 32'd5;
    idle_check("startstop", 8);

    write_reg(0, 32'd0); write_reg(1, 32'd2000);
    strobes_seen = 0;
    run("wrap", 1'b0, 1028, -1, -1);
    check_val("wrap_count", 64'(strobes_seen), 64'd1024);

    for (int r = 0; r < 12; r++) begin
      if (!prev_active) begin
        write_reg(0, $urandom_range(0, 3));
        write_reg(1, $urandom_range(1, 12));
        write_reg(2, $urandom_range(0, 4));
      end
      lp = ($urandom_range(0, 1) == 1);
      nc = lp ? int'($urandom_range(10, 50)) : rN * (rI + 1) + 3;
      sa = (lp && $urandom_range(0, 2) == 0) ? int'($urandom_range(2, nc - 1)) : -1;
      ni = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      run("rand", lp, nc, sa, ni);
    end

    run("pre_rst", 1'b1, 8, -1, -1);
    #2 reset = 1'b0;
    #1;
    m_sample = 32'd0; m_loops = 0; prev_active = 1'b0; rI = 0; rN = 0; rG = 0;
    check_outputs("rst_async", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    reset = 1'b1;
    set_stb = 1'b1; set_addr = SR_BASE + 8'd3; set_data = 32'd1;
    idle_check("rst_len0", 4);
    write_reg(0, 32'd2); write_reg(1, 32'd5); write_reg(2, 32'd0);
    run("after_rst", 1'b0, 18, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
